// File: rtl/dsp_pkg.sv
// Shared fixed-point constants, saturation bounds and the oscillator state type
// used by the tone generator and the resonator filter.
package dsp_pkg;

  localparam int SYSTEM_FREQUENCY = 50_000_000;

  localparam int Q88_W     = 16;
  localparam int Q88_FRAC  = 8;
  localparam int Q214_W    = 16;
  localparam int Q214_FRAC = 14;

  localparam logic signed [Q88_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [Q88_W-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } osc_state_t;

endpackage

// File: rtl/resonator_tone_generator_if.sv
// Control and sample-stream bundle between a controller (master) and the tone generator (slave).
interface resonator_tone_generator_if;
   import dsp_pkg::*;

   logic                start;
   logic                stop;
   logic [Q214_W-1:0]   coef;
   logic [Q88_W-1:0]    init_y1;
   logic [Q88_W-1:0]    init_y2;
   logic [Q88_W-1:0]    q;
   logic                q_valid;
   logic                q_ready;
   logic                busy;
   logic                sat;
   logic                overrun;

   // Sample stream: q is transferred on any cycle where q_valid & q_ready are both
   // high; while q_valid & !q_ready, q is held unless a newer sample replaces it.
   modport master (
      output start, stop, coef, init_y1, init_y2, q_ready,
      input  q, q_valid, busy, sat, overrun
   );

   modport slave (
      input  start, stop, coef, init_y1, init_y2, q_ready,
      output q, q_valid, busy, sat, overrun
   );

endinterface

// File: rtl/sample_rate_timebase.sv
// Free-running 0..CLOCK_TICKS-1 counter with synchronous clear; tick marks the last count.
module sample_rate_timebase #(
   parameter int CLOCK_TICKS = 100_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int             CW   = (CLOCK_TICKS > 1) ? $clog2(CLOCK_TICKS) : 1;
   localparam logic [CW-1:0]  LAST = CW'(CLOCK_TICKS - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= (count == LAST) ? '0 : count + CW'(1);
      end
   end

   assign tick = enable & ~clear & (count == LAST);

endmodule

// File: rtl/resonator_tone_generator.sv
// Recursive sine oscillator y[n] = c*y[n-1] - y[n-2] producing one saturated Q8.8
// sample per sampling tick on a valid/ready stream that never back-pressures the oscillator.
module resonator_tone_generator
   import dsp_pkg::*;
#(
   parameter int SYSTEM_FREQUENCY   = dsp_pkg::SYSTEM_FREQUENCY,
   parameter int SAMPLING_FREQUENCY = 500,
   parameter int DATA_WIDTH         = 16,
   parameter int COEF_FRAC          = 14
) (
   input  logic                        clk,
   input  logic                        reset_n,
   resonator_tone_generator_if.slave   bus,
   output osc_state_t                  dbg_state
);

   localparam int CLOCK_TICKS = SYSTEM_FREQUENCY / SAMPLING_FREQUENCY;
   localparam int PW          = 2 * DATA_WIDTH;
   localparam int SW          = DATA_WIDTH + 3;

   osc_state_t                    state;
   logic                          busy;
   logic signed [DATA_WIDTH-1:0]  c_reg;
   logic signed [DATA_WIDTH-1:0]  y1;
   logic signed [DATA_WIDTH-1:0]  y2;
   logic signed [DATA_WIDTH-1:0]  q;
   logic                          q_valid;
   logic                          sat;
   logic                          overrun;

   logic                          tick;
   logic                          tick_eff;
   logic signed [PW-1:0]          p;
   logic signed [SW-1:0]          s;
   logic signed [DATA_WIDTH-1:0]  y_new;
   logic                          clip;

   sample_rate_timebase #(
      .CLOCK_TICKS (CLOCK_TICKS)
   ) u_timebase (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (state != RUN),
      .enable  (state == RUN),
      .tick    (tick)
   );

   // A stop landing on a tick wins, so no sample is produced on the way out.
   assign tick_eff = tick & ~bus.stop;

   always_comb begin
      p     = c_reg * y1;
      s     = SW'(p >>> COEF_FRAC) - $signed({{3{y2[DATA_WIDTH-1]}}, y2});
      clip  = 1'b0;
      y_new = s[DATA_WIDTH-1:0];
      if (s > $signed(SW'(SAT_MAX))) begin
         y_new = SAT_MAX;
         clip  = 1'b1;
      end else if (s < $signed(SW'(SAT_MIN))) begin
         y_new = SAT_MIN;
         clip  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               state <= LOAD;
               busy  <= 1'b1;
            end
            LOAD: begin
               state <= RUN;
               busy  <= 1'b1;
            end
            RUN: if (bus.stop) begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         c_reg   <= '0;
         y1      <= '0;
         y2      <= '0;
         q       <= '0;
         q_valid <= 1'b0;
         sat     <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (state == LOAD) begin
            c_reg   <= bus.coef;
            y1      <= bus.init_y1;
            y2      <= bus.init_y2;
            sat     <= 1'b0;
            overrun <= 1'b0;
         end else if (tick_eff) begin
            y2 <= y1;
            y1 <= y_new;
            if (clip) sat <= 1'b1;
         end

         // Ticks only occur in RUN, so this never collides with the LOAD clears.
         if (tick_eff) begin
            q       <= y_new;
            q_valid <= 1'b1;
            if (q_valid && !bus.q_ready) overrun <= 1'b1;
         end else if (q_valid && bus.q_ready) begin
            q_valid <= 1'b0;
         end
      end
   end

   assign bus.q       = q;
   assign bus.q_valid = q_valid;
   assign bus.busy    = busy;
   assign bus.sat     = sat;
   assign bus.overrun = overrun;
   assign dbg_state   = state;

endmodule
